fifo_rd_drain: RTL and testbench

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/fifo_rd_drain.sv | 95 +++++++++
 tb/tb_fifo_rd_drain.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Drains a read-latency-1 FIFO into a valid/ready stream via a 3-entry skid buffer; rd_count stats under FIFO_RD_DRAIN_STATS_EN.
// Latency: first m_valid two cycles after fifo_empty falls, then one word per cycle.
// Backpressure: reads are issued only when buffer plus in-flight slots fit, so m_ready never reaches fifo_rd_en.
module fifo_rd_drain #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  err_underflow,
    output logic [15:0]           rd_count
);

    localparam int DEPTH = 3;

    logic [FIFO_WIDTH-1:0] buf_q [DEPTH];
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        capture    = inflight_q && !fifo_underflow;
        pop        = (occ_q != 2'd0) && m_ready;
        // Reserve a slot for the word already in flight so a capture can never be dropped.
        fifo_rd_en = rst_n && !fifo_empty &&
                     (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
        inflight_d = fifo_rd_en;
        err_d      = err_q || (inflight_q && fifo_underflow);
        head_d     = pop ? ptr_inc(head_q) : head_q;
        tail_d     = capture ? ptr_inc(tail_q) : tail_q;
        occ_d      = occ_q;
        case ({capture, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (capture) begin
                buf_q[tail_q] <= fifo_data_out;
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = buf_q[head_q];
    assign err_underflow = err_q;

`ifdef FIFO_RD_DRAIN_STATS_EN
    logic [15:0] rd_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= 16'd0;
        end else if (pop && (rd_count_q != 16'hFFFF)) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
`else
    assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: upstream FIFO model feeds an expected-word queue that a stream monitor consumes.
module tb_fifo_rd_drain;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty;
    logic         fifo_underflow = 1'b0;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         err_underflow;
    logic [15:0]  rd_count;

    int checks = 0;
    int errors = 0;

    // Upstream FIFO contents: words are appended at index pushed, read at index popped.
    logic [W-1:0] store [0:4095];
    int           pushed = 0;
    int           popped = 0;
    int           uf_idx = -1;
    int           rd_pulses = 0;
    logic [W-1:0] exp_q [$];

    assign fifo_empty = (pushed == popped);

    fifo_rd_drain #(.FIFO_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .err_underflow  (err_underflow),
        .rd_count       (rd_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: read data appears one cycle after an accepted read; a poisoned read raises underflow instead.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses     <= rd_pulses + 1;
            popped        <= popped + 1;
            fifo_data_out <= store[popped];
            if (popped == uf_idx) begin
                fifo_underflow <= 1'b1;
            end else begin
                fifo_underflow <= 1'b0;
                exp_q.push_back(store[popped]);
            end
        end else begin
            fifo_underflow <= 1'b0;
        end
    end

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {16'd0, m_data}, {16'd0, prev_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h, expected no word", m_data);
                end else begin
                    check("stream_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                end
            end
`ifndef FIFO_RD_DRAIN_STATS_EN
            check("rd_count_zero", {16'd0, rd_count}, 32'd0);
`endif
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        store[pushed] = d;
        pushed++;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || pushed != popped || m_valid) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || pushed != popped || m_valid) begin
            errors++;
            $display("FAIL %s_drain: %0d words still pending after %0d cycles, expected 0",
                     tag, exp_q.size(), max);
        end
    endtask

    logic [W-1:0] w [5];
    int           base;

    initial begin
        // Reset with a non-empty FIFO: no read may be issued.
        push(16'hAAAA);
        repeat (2) tick();
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_err", {31'd0, err_underflow}, 32'd0);
        check("rst_rd_count", {16'd0, rd_count}, 32'd0);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        drain("initial", 20);

        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Streaming: 8 words, one per cycle, first valid two cycles after fifo_empty falls.
        for (int k = 1; k <= 8; k++) push(W'(k));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 2) begin
                check("stream_latency", {31'd0, m_valid}, 32'd0);
            end else begin
                check("stream_valid", {31'd0, m_valid}, 32'd1);
                check("stream_seq", {16'd0, m_data}, c - 1);
            end
        end
        @(negedge clk);
        check("stream_end_valid", {31'd0, m_valid}, 32'd0);
`ifdef FIFO_RD_DRAIN_STATS_EN
        check("stream_rd_count", {16'd0, rd_count}, 32'd8);
`endif
        tick();

        // Backpressure: only three reads while the output is stalled.
        m_ready = 1'b0;
        base    = rd_pulses;
        for (int k = 0; k < 5; k++) begin
            w[k] = W'($urandom);
            push(w[k]);
        end
        repeat (8) tick();
        check("bp_rd_pulses", rd_pulses - base, 32'd3);
        check("bp_valid", {31'd0, m_valid}, 32'd1);
        check("bp_head", {16'd0, m_data}, {16'd0, w[0]});
        m_ready = 1'b1;
        drain("backpressure", 30);
        check("bp_total_reads", rd_pulses - base, 32'd5);

        // Underflow on the first of two reads: it is dropped, the second still arrives.
        tick();
        uf_idx = pushed;
        push(16'h1111);
        push(16'h2222);
        @(negedge clk);
        check("uf_err_before", {31'd0, err_underflow}, 32'd0);
        @(negedge clk);
        check("uf_err_inflight", {31'd0, err_underflow}, 32'd0);
        @(negedge clk);
        check("uf_err_set", {31'd0, err_underflow}, 32'd1);
        check("uf_no_capture", {31'd0, m_valid}, 32'd0);
        tick();
        drain("underflow", 20);
        repeat (5) tick();
        check("uf_err_sticky", {31'd0, err_underflow}, 32'd1);
        uf_idx = -1;

        // Reset with two words buffered and one read in flight.
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w[k] = W'($urandom);
            push(w[k]);
        end
        repeat (3) tick();
        check("mid_pre_valid", {31'd0, m_valid}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("mid_rd_count", {16'd0, rd_count}, 32'd0);
        check("mid_m_data", {16'd0, m_data}, 32'd0);
        check("mid_err_cleared", {31'd0, err_underflow}, 32'd0);
        repeat (2) tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        if (m_valid) check("mid_resume", {16'd0, m_data}, {16'd0, w[3]});
        drain("midreset", 20);

        // Counter saturation.
        tick();
`ifdef FIFO_RD_DRAIN_STATS_EN
        dut.rd_count_q = 16'hFFFE;
`endif
        for (int k = 0; k < 3; k++) push(W'($urandom));
        drain("saturate", 20);
`ifdef FIFO_RD_DRAIN_STATS_EN
        check("sat_rd_count", {16'd0, rd_count}, 32'h0000FFFF);
`else
        check("nostats_rd_count", {16'd0, rd_count}, 32'd0);
`endif

        // Random traffic and random stalls.
        for (int it = 0; it < 400; it++) begin
            tick();
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) push(W'($urandom));
            end
        end
        tick();
        m_ready = 1'b1;
        drain("random", 300);
        check("final_err_clear", {31'd0, err_underflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
